// File: rtl/oled_pkg.sv
// oled_pkg: shared constants, FSM state encoding and the cursor-advance helper
// used by the OLED text feeder. The panel is 128x32 px, which gives 16 columns
// of 8 px glyphs on 4 text lines.
package oled_pkg;

  localparam int CHARS_PER_LINE = 16;
  localparam int NUM_LINES      = 4;

  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_LF    = 8'h0A;

  localparam logic [3:0] LAST_COL  = 4'(CHARS_PER_LINE - 1);
  localparam logic [1:0] LAST_LINE = 2'(NUM_LINES - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_OFFER   = 2'd1,
    ST_RELEASE = 2'd2,
    ST_PAD     = 2'd3
  } feed_state_t;

  // Cursor position after one glyph: the column steps and wraps, and the line
  // steps only on a column wrap. The bottom line wraps back to the top line.
  // Returns {line, col}.
  function automatic logic [5:0] advance_cursor(input logic [3:0] col,
                                                input logic [1:0] line);
    logic [3:0] ncol;
    logic [1:0] nline;
    if (col == LAST_COL) begin
      ncol = 4'd0;
      if (line == LAST_LINE) nline = 2'd0;
      else                   nline = line + 2'd1;
    end else begin
      ncol  = col + 4'd1;
      nline = line;
    end
    return {nline, ncol};
  endfunction

endpackage

// File: rtl/oled_text_feeder_char_fifo.sv
// char_fifo: synchronous single-clock FIFO that buffers characters for the
// feeder.
//   clock, reset : clock and asynchronous active-high reset (empties the FIFO)
//   wr_en/wr_data: push. A push is ignored while full.
//   rd_en        : pop the head entry. A pop is ignored while empty.
//   rd_data      : head entry, visible combinationally
//   full/empty   : registered occupancy flags
// DEPTH must be a power of two so that the pointers wrap by natural overflow.
module char_fifo #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;
  logic [AW:0]       count_next;
  logic              do_wr;
  logic              do_rd;

  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  // Occupancy after this cycle. A simultaneous push and pop leave it unchanged.
  always_comb begin
    count_next = count;
    case ({do_wr, do_rd})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  // Pointers, count and the registered flags.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
      full  <= (count_next == FULL_COUNT);
      empty <= (count_next == '0);
    end
  end

  // Storage array. Reset discards the contents through the pointers, so the
  // array itself needs no reset.
  always_ff @(posedge clock) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/oled_text_feeder.sv
// oled_text_feeder: character source for the OLED controller.
// It buffers ASCII bytes in a FIFO and offers them one at a time on
// sendData/sendDataValid. Each character is held until the controller's
// sendDone. The block also tracks the text cursor on a 16x4 character grid.
//   clock, reset         : clock and asynchronous active-high reset
//   wr_data, wr_en       : producer push (dropped while fifo_full)
//   fifo_full/fifo_empty : FIFO occupancy
//   overflow             : sticky flag, set when a push is attempted while full
//   sendData/Valid       : character offered to the controller
//   sendDone             : controller level ack, held for several cycles
//   busy                 : FSM active or FIFO non-empty
//   col_pos, line_pos    : cursor position of the next glyph
// Optional feature: define OLED_FEED_NEWLINE_EN to expand a popped 0x0A into
// spaces up to the end of the current line. 0x0A itself is never sent.
module oled_text_feeder
  import oled_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_en,
  output logic              fifo_full,
  output logic              fifo_empty,
  output logic              overflow,
  output logic [DATA_W-1:0] sendData,
  output logic              sendDataValid,
  input  logic              sendDone,
  output logic              busy,
  output logic [3:0]        col_pos,
  output logic [1:0]        line_pos
);

  feed_state_t       state;
  logic              pop;
  logic [DATA_W-1:0] fifo_head;
`ifdef OLED_FEED_NEWLINE_EN
  logic [4:0]        pad_cnt;
`endif

  char_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_en   (pop),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // The head is consumed only when the FSM is idle and something is queued.
  always_comb begin
    if ((state == ST_IDLE) && !fifo_empty) pop = 1'b1;
    else                                   pop = 1'b0;
  end

  assign busy = (state != ST_IDLE) || !fifo_empty;

  // Sticky overflow flag. Only reset clears it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (wr_en && fifo_full) begin
      overflow <= 1'b1;
    end
  end

  // Feeder FSM with registered handshake outputs and cursor.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= ST_IDLE;
      sendData      <= '0;
      sendDataValid <= 1'b0;
      col_pos       <= 4'd0;
      line_pos      <= 2'd0;
`ifdef OLED_FEED_NEWLINE_EN
      pad_cnt       <= 5'd0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
`ifdef OLED_FEED_NEWLINE_EN
            // A line feed is swallowed and becomes spaces up to the end of the
            // line. At column 0 that is a full blank line of 16 spaces.
            if (fifo_head == DATA_W'(ASCII_LF)) begin
              pad_cnt <= 5'd16 - {1'b0, col_pos};
              state   <= ST_PAD;
            end else begin
              sendData      <= fifo_head;
              sendDataValid <= 1'b1;
              state         <= ST_OFFER;
            end
`else
            sendData      <= fifo_head;
            sendDataValid <= 1'b1;
            state         <= ST_OFFER;
`endif
          end
        end
        ST_OFFER: begin
          if (sendDone) begin
            sendDataValid         <= 1'b0;
            {line_pos, col_pos}   <= advance_cursor(col_pos, line_pos);
            state                 <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          // Wait for sendDone to drop so that one level pulse never acks two
          // glyphs.
          if (!sendDone) begin
`ifdef OLED_FEED_NEWLINE_EN
            if (pad_cnt != 5'd0) state <= ST_PAD;
            else                 state <= ST_IDLE;
`else
            state <= ST_IDLE;
`endif
          end
        end
`ifdef OLED_FEED_NEWLINE_EN
        ST_PAD: begin
          sendData      <= DATA_W'(ASCII_SPACE);
          sendDataValid <= 1'b1;
          pad_cnt       <= pad_cnt - 5'd1;
          state         <= ST_OFFER;
        end
`endif
        default: begin
          state         <= ST_IDLE;
          sendDataValid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_oled_text_feeder.sv
`timescale 1ns/1ps
// Self-checking bench for oled_text_feeder.
// A scoreboard queue holds the expected glyph, column and line for every offer.
// The bench fills it when characters are written, and a monitor pops and
// compares it each time sendDataValid rises.
module tb_oled_text_feeder;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] wr_data;
  logic       wr_en;
  logic       fifo_full, fifo_empty, overflow;
  logic [7:0] sendData;
  logic       sendDataValid;
  logic       sendDone;
  logic       busy;
  logic [3:0] col_pos;
  logic [1:0] line_pos;

  logic ctrl_done, man_done, ctrl_en;
  int   ctrl_delay;
  int   n_vec = 0, n_err = 0, n_offers = 0, n_pulses = 0;

  assign sendDone = ctrl_done | man_done;

  always #5 clock = ~clock;

  oled_text_feeder #(.DEPTH(16), .DATA_W(8)) dut (
    .clock(clock), .reset(reset), .wr_data(wr_data), .wr_en(wr_en),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .overflow(overflow),
    .sendData(sendData), .sendDataValid(sendDataValid), .sendDone(sendDone),
    .busy(busy), .col_pos(col_pos), .line_pos(line_pos)
  );

  typedef struct { logic [7:0] ch; logic [3:0] col; logic [1:0] line; } exp_t;
  exp_t       sb[$];
  logic [3:0] mcol;
  logic [1:0] mline;

  typedef struct { logic [7:0] ch; logic exp_full; logic exp_empty; logic exp_ovf; } vec_t;
  vec_t tab[17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void push_glyph(input logic [7:0] ch);
    exp_t e;
    e.ch = ch; e.col = mcol; e.line = mline;
    sb.push_back(e);
    if (mcol == 4'd15) mline = mline + 2'd1;
    mcol = mcol + 4'd1;
  endfunction

  function automatic void push_char(input logic [7:0] ch);
    int n;
    n = 0;
`ifdef OLED_FEED_NEWLINE_EN
    if (ch == 8'h0A) n = 16 - int'(mcol);
`endif
    if (n > 0) begin
      for (int i = 0; i < n; i++) push_glyph(8'h20);
    end else begin
      push_glyph(ch);
    end
  endfunction

  // Monitor: compare each new offer against the scoreboard, and check that
  // sendData holds steady while it is offered.
  initial begin : monitor
    logic       prev_v;
    logic [7:0] held;
    exp_t       e;
    prev_v = 1'b0;
    held   = 8'h00;
    forever begin
      @(negedge clock);
      if (sendDataValid && !prev_v) begin
        n_offers++;
        if (sb.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL spurious_offer: got 0x%0h, expected no offer", sendData);
        end else begin
          e = sb.pop_front();
          check("offer_data", 32'(sendData), 32'(e.ch));
          check("offer_col",  32'(col_pos),  32'(e.col));
          check("offer_line", 32'(line_pos), 32'(e.line));
        end
        held = sendData;
      end else if (sendDataValid && prev_v) begin
        check("data_stable", 32'(sendData), 32'(held));
      end
      prev_v = sendDataValid;
    end
  end

  // Controller model: after ctrl_delay cycles it raises sendDone for 5 cycles.
  initial begin : controller
    ctrl_done = 1'b0;
    forever begin
      @(negedge clock);
      if (ctrl_en && sendDataValid && !reset) begin
        for (int i = 0; i < ctrl_delay && !reset; i++) @(negedge clock);
        if (!reset) begin
          ctrl_done = 1'b1;
          n_pulses++;
          for (int i = 0; i < 5; i++) @(negedge clock);
          ctrl_done = 1'b0;
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  // All tasks below are called just after a negedge.
  task automatic write_char(input logic [7:0] ch, input bit push);
    wr_en = 1'b1; wr_data = ch;
    if (push) push_char(ch);
    @(negedge clock);
    wr_en = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int k;
    k = 0;
    while ((sb.size() != 0 || busy) && k < budget) begin
      @(negedge clock); k++;
    end
    check(name, 32'((sb.size() == 0) && !busy), 32'd1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    sb.delete(); mcol = 4'd0; mline = 2'd0;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
  endtask

  // Manual ack: one sendDone pulse. On return the FSM is back in IDLE.
  task automatic manual_release();
    man_done = 1'b1;
    @(negedge clock);
    man_done = 1'b0;
    @(negedge clock);
  endtask

  initial begin : main
    int p0, o0, k;
    for (int i = 0; i < 17; i++) begin
      tab[i].ch        = 8'(8'h61 + i);
      tab[i].exp_full  = (i >= 15);
      tab[i].exp_empty = 1'b0;
      tab[i].exp_ovf   = (i == 16);
    end
    reset = 1'b1; wr_en = 1'b0; wr_data = 8'h00; man_done = 1'b0;
    ctrl_en = 1'b0; ctrl_delay = 2; mcol = 4'd0; mline = 2'd0;
    repeat (3) @(negedge clock);
    check("rst_valid",    32'(sendDataValid), 32'd0);
    check("rst_data",     32'(sendData),      32'd0);
    check("rst_empty",    32'(fifo_empty),    32'd1);
    check("rst_full",     32'(fifo_full),     32'd0);
    check("rst_overflow", 32'(overflow),      32'd0);
    check("rst_busy",     32'(busy),          32'd0);
    check("rst_col",      32'(col_pos),       32'd0);
    check("rst_line",     32'(line_pos),      32'd0);
    reset = 1'b0;
    @(negedge clock);

    // Test 1: single glyph, latency and ack timing.
    write_char(8'h41, 1'b1);
    check("t1_valid_edgeN", 32'(sendDataValid), 32'd0);
    @(negedge clock);
    check("t1_valid_edgeN1", 32'(sendDataValid), 32'd1);
    check("t1_data",         32'(sendData),      32'h41);
    repeat (39) @(negedge clock);
    man_done = 1'b1;
    @(negedge clock);
    check("t1_valid_drop", 32'(sendDataValid), 32'd0);
    check("t1_col",        32'(col_pos),       32'd1);
    repeat (4) @(negedge clock);
    man_done = 1'b0;
    wait_drain("t1_drain", 100);

    // Test 2: the FSM stalls holding one glyph while 17 writes hit the FIFO.
    write_char(8'h70, 1'b1);
    @(negedge clock);
    for (int i = 0; i < 17; i++) begin
      wr_en = 1'b1; wr_data = tab[i].ch;
      if (i < 16) push_char(tab[i].ch);
      @(negedge clock);
      check("t2_full",     32'(fifo_full),  32'(tab[i].exp_full));
      check("t2_empty",    32'(fifo_empty), 32'(tab[i].exp_empty));
      check("t2_overflow", 32'(overflow),   32'(tab[i].exp_ovf));
    end
    wr_en = 1'b0;
    ctrl_en = 1'b1; ctrl_delay = 3;
    wait_drain("t2_drain", 3000);
    check("t2_overflow_sticky", 32'(overflow), 32'd1);
    ctrl_en = 1'b0;

    // Test 6a: a push coincides with the pop while the FIFO is full.
    do_reset();
    write_char(8'h50, 1'b1);
    @(negedge clock);
    for (int i = 0; i < 16; i++) write_char(8'(8'h30 + i), 1'b1);
    check("t6_full",        32'(fifo_full), 32'd1);
    check("t6_no_overflow", 32'(overflow),  32'd0);
    manual_release();
    write_char(8'h7E, 1'b0);
    check("t6_overflow",       32'(overflow),  32'd1);
    check("t6_full_after_pop", 32'(fifo_full), 32'd0);
    ctrl_en = 1'b1;
    wait_drain("t6a_drain", 3000);
    ctrl_en = 1'b0;

    // Test 6b: a push coincides with the pop while the FIFO is half full.
    write_char(8'h30, 1'b1);
    @(negedge clock);
    for (int i = 1; i <= 8; i++) write_char(8'(8'h30 + i), 1'b1);
    manual_release();
    write_char(8'h39, 1'b1);
    check("t6b_empty", 32'(fifo_empty), 32'd0);
    check("t6b_full",  32'(fifo_full),  32'd0);
    ctrl_en = 1'b1;
    wait_drain("t6b_drain", 3000);

    // Test 3: 64 glyphs cover all columns and lines, then the line wraps 3 -> 0.
    do_reset();
    ctrl_en = 1'b1; ctrl_delay = 1;
    p0 = n_pulses; o0 = n_offers;
    for (int i = 0; i < 64; i++) begin
      k = 0;
      while (fifo_full && k < 500) begin @(negedge clock); k++; end
      write_char(8'(8'h40 + i), 1'b1);
    end
    wait_drain("t3_drain", 5000);
    check("t3_offers", 32'(n_offers - o0), 32'd64);
    check("t3_pulses", 32'(n_pulses - p0), 32'd64);
    check("t3_col",    32'(col_pos),       32'd0);
    check("t3_line",   32'(line_pos),      32'd0);

    // Test 4: line feed handling.
    do_reset();
    write_char(8'h48, 1'b1);
    write_char(8'h69, 1'b1);
    write_char(8'h0A, 1'b1);
    write_char(8'h58, 1'b1);
    wait_drain("t4_drain", 3000);
    check("t4_col",  32'(col_pos),  32'(mcol));
    check("t4_line", 32'(line_pos), 32'(mline));
    ctrl_en = 1'b0;

    // Test 5: asynchronous reset while a glyph is being offered.
    write_char(8'h51, 1'b1);
    @(negedge clock);
    for (int i = 0; i < 17; i++) write_char(8'h52, 1'b0);
    check("t5_pre_overflow", 32'(overflow),      32'd1);
    check("t5_pre_valid",    32'(sendDataValid), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("t5_async_valid", 32'(sendDataValid), 32'd0);
    check("t5_empty",       32'(fifo_empty),    32'd1);
    check("t5_overflow",    32'(overflow),      32'd0);
    check("t5_busy",        32'(busy),          32'd0);
    check("t5_col",         32'(col_pos),       32'd0);
    sb.delete(); mcol = 4'd0; mline = 2'd0;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    ctrl_en = 1'b1;
    write_char(8'h52, 1'b1);
    wait_drain("t5_drain", 500);
    check("t5_col_after", 32'(col_pos), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
